// File: rtl/tog_event_pkg.sv
// Shared types and helpers for the toggle-event decoder.
package tog_event_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } filt_state_e;

  localparam int FILT_CNT_W = 4;

  function automatic int unsigned sat_val(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/tog_filter.sv
// Glitch filter that turns each qualified level change of tog_in into one accept pulse.
// Optional input synchronizer selected by TOG_EVENT_DECODER_SYNC_EN.
//
// state   | meaning
// STABLE  | input matches ref_lvl, waiting for a change
// QUALIFY | input differs, counting consecutive differing samples
module tog_filter
  import tog_event_pkg::*;
#(
  parameter int FILT_LEN = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tog_in,
  output logic accept,
  output logic glitch_det
);

  localparam logic [FILT_CNT_W-1:0] LEN_C = FILT_CNT_W'(FILT_LEN);

  logic samp;

`ifdef TOG_EVENT_DECODER_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], tog_in};
  end

  assign samp = sync_q[1];
`else
  assign samp = tog_in;
`endif

  filt_state_e           state_q, state_d;
  logic                  ref_q, ref_d;
  logic [FILT_CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STABLE;
      ref_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ref_d      = ref_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    glitch_det = 1'b0;
    case (state_q)
      STABLE: begin
        if (samp != ref_q) begin
          if (FILT_LEN == 1) begin
            accept = 1'b1;
            ref_d  = ~ref_q;
          end else begin
            state_d = QUALIFY;
            cnt_d   = FILT_CNT_W'(1);
          end
        end
      end
      QUALIFY: begin
        if (samp == ref_q) begin
          state_d    = STABLE;
          cnt_d      = '0;
          glitch_det = 1'b1;
        end else if (cnt_q + FILT_CNT_W'(1) == LEN_C) begin
          accept  = 1'b1;
          ref_d   = ~ref_q;
          state_d = STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + FILT_CNT_W'(1);
        end
      end
      default: state_d = STABLE;
    endcase
  end

endmodule

// File: rtl/tog_event_decoder.sv
// Toggle-line event decoder: filter, saturating pending counter, sticky flags, valid/ready.
// Define TOG_EVENT_DECODER_SYNC_EN to add a 2-flop input synchronizer in front of the filter.
module tog_event_decoder
  import tog_event_pkg::*;
#(
  parameter int FILT_LEN = 2,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tog_in,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [CNT_W-1:0] pending,
  output logic             ovf,
  output logic             glitch,
  input  logic             flag_clr
);

  localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(sat_val(CNT_W));

  logic             accept, glitch_det, take;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             ovf_q, ovf_d;
  logic             glitch_q, glitch_d;

  tog_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_filter (
    .clk        (clk),
    .rst        (rst),
    .tog_in     (tog_in),
    .accept     (accept),
    .glitch_det (glitch_det)
  );

  assign take = (pending_q != '0) && ev_ready;

  always_comb begin
    pending_d = pending_q;
    ovf_d     = ovf_q & ~flag_clr;
    glitch_d  = (glitch_q & ~flag_clr) | glitch_det;
    if (accept && !take) begin
      // At saturation the event is dropped; the filter has already realigned ref_lvl.
      if (pending_q == PEND_MAX) ovf_d = 1'b1;
      else                       pending_d = pending_q + 1'b1;
    end else if (take && !accept) begin
      pending_d = pending_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      ovf_q     <= 1'b0;
      glitch_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      glitch_q  <= glitch_d;
    end
  end

  assign ev_valid = (pending_q != '0);
  assign pending  = pending_q;
  assign ovf      = ovf_q;
  assign glitch   = glitch_q;

endmodule

// File: tb/tb_tog_event_decoder.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_tog_event_decoder;

  localparam int FILT_LEN = 2;
  localparam int CNT_W    = 2;
  localparam int PMAX     = (1 << CNT_W) - 1;
`ifdef TOG_EVENT_DECODER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tog_in = 1'b0;
  logic             ev_ready = 1'b0;
  logic             flag_clr = 1'b0;
  logic             ev_valid;
  logic [CNT_W-1:0] pending;
  logic             ovf;
  logic             glitch;

  tog_event_decoder #(
    .FILT_LEN (FILT_LEN),
    .CNT_W    (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tog_in   (tog_in),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .pending  (pending),
    .ovf      (ovf),
    .glitch   (glitch),
    .flag_clr (flag_clr)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic lvl   = 1'b0;

  // Model: reference level, run length of samples differing from it, delay line for the synchronizer.
  logic m_ref;
  int   m_run;
  int   m_pend;
  logic m_ovf, m_gl;
  logic dly [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model(input logic t, input logic rdy, input logic clr, input logic r);
    logic s;
    bit   acc, gl, take;
    if (r) begin
      m_ref = 0; m_run = 0; m_pend = 0; m_ovf = 0; m_gl = 0;
      dly[0] = 0; dly[1] = 0;
      return;
    end
    if (LAT > 0) begin
      s = dly[1]; dly[1] = dly[0]; dly[0] = t;
    end else begin
      s = t;
    end
    acc = 0; gl = 0;
    if (s != m_ref) begin
      m_run++;
      if (m_run == FILT_LEN) begin
        acc = 1; m_ref = ~m_ref; m_run = 0;
      end
    end else begin
      gl = (m_run > 0);
      m_run = 0;
    end
    take = (m_pend > 0) && rdy;
    if (clr) begin m_ovf = 0; m_gl = 0; end
    if (gl) m_gl = 1;
    if (acc && !take) begin
      if (m_pend == PMAX) m_ovf = 1;
      else m_pend++;
    end else if (take && !acc) begin
      m_pend--;
    end
  endtask

  task automatic step(input logic t, input logic rdy, input logic clr, input logic r);
    tog_in = t; ev_ready = rdy; flag_clr = clr; rst = r;
    @(posedge clk);
    cyc++;
    model(t, rdy, clr, r);
    #1;
    chk("valid",   32'(ev_valid), 32'(m_pend != 0));
    chk("pending", 32'(pending),  32'(m_pend));
    chk("ovf",     32'(ovf),      32'(m_ovf));
    chk("glitch",  32'(glitch),   32'(m_gl));
    @(negedge clk);
  endtask

  // Move the line to level l; ev_ready only in the last (accept) cycle when rdy_last is set.
  task automatic toggle_to(input logic l, input int hold_n, input logic rdy_last);
    lvl = l;
    for (int i = 0; i < hold_n; i++)
      step(l, (i == hold_n - 1) ? rdy_last : 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    model(0, 0, 0, 1);
    @(negedge clk);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rst_valid", 32'(ev_valid), 0);
    chk("rst_pend",  32'(pending),  0);
    chk("rst_flags", 32'({ovf, glitch}), 0);

    // Single change: valid rises FILT_LEN-1+LAT edges after the change edge.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    lvl = 1;
    chk("s1_early", 32'(ev_valid), 0);
    for (int i = 0; i < FILT_LEN - 1 + LAT; i++) begin
      if (i == FILT_LEN - 2 + LAT) begin
        step(1, 0, 0, 0);
        chk("s1_valid", 32'(ev_valid), 1);
        chk("s1_pend",  32'(pending),  1);
      end else begin
        step(1, 0, 0, 0);
        chk("s1_notyet", 32'(ev_valid), 0);
      end
    end
    step(1, 1, 0, 0);
    chk("s1_take_pend",  32'(pending),  0);
    chk("s1_take_valid", 32'(ev_valid), 0);

    // One-cycle glitch low: no event, glitch flag, reference level unchanged.
    step(0, 0, 0, 0);
    for (int i = 0; i < LAT + 3; i++) step(1, 0, 0, 0);
    chk("gl_flag", 32'(glitch),  1);
    chk("gl_pend", 32'(pending), 0);
    step(1, 0, 1, 0);
    chk("gl_clr", 32'(glitch), 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    chk("gl_noevent", 32'(pending), 0);

    // Saturation with ev_ready low, then a 5th toggle taken in its accept cycle.
    for (int k = 0; k < 4; k++) toggle_to(~lvl, FILT_LEN + LAT + 1, 1'b0);
    chk("sat_pend", 32'(pending), PMAX);
    chk("sat_ovf",  32'(ovf),     1);
    toggle_to(~lvl, FILT_LEN + LAT, 1'b1);
    chk("sat_take_pend", 32'(pending), PMAX);
    chk("sat_take_ovf",  32'(ovf),     1);
    step(lvl, 0, 1, 0);
    chk("sat_ovf_clr", 32'(ovf), 0);

    // Drain to one, then accept and take in the same cycle.
    step(lvl, 1, 0, 0);
    step(lvl, 1, 0, 0);
    chk("sim_pre", 32'(pending), 1);
    toggle_to(~lvl, FILT_LEN + LAT, 1'b1);
    chk("sim_pend",  32'(pending),  1);
    chk("sim_valid", 32'(ev_valid), 1);

    // Reset mid-qualification with two pending, then a held high level qualifies from ref 0.
    toggle_to(~lvl, FILT_LEN + LAT + 1, 1'b0);
    chk("rq_pre", 32'(pending), 2);
    step(~lvl, 0, 0, 0);
    step(1, 0, 0, 1);
    chk("rq_pend",  32'(pending),  0);
    chk("rq_valid", 32'(ev_valid), 0);
    chk("rq_flags", 32'({ovf, glitch}), 0);
    for (int i = 0; i < FILT_LEN + LAT; i++) step(1, 0, 0, 0);
    chk("rq_event", 32'(pending), 1);
    lvl = 1;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 30) lvl = ~lvl;
      step(lvl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 299) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
